// File: rtl/sni_bitap_matcher.sv
// Shift-or (bitap) hostname matcher: BPC bytes per beat, runtime mask table, per-packet verdict.
// Build option SNI_BITAP_GAP_EN adds per-position wildcard self-loops driven by i_cfg_gap.
module sni_bitap_matcher #(
  parameter int unsigned BPC     = 2,
  parameter int unsigned PAT_MAX = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cfg_we,
  input  logic [7:0]         i_cfg_addr,
  input  logic [PAT_MAX-1:0] i_cfg_mask,
  input  logic [4:0]         i_cfg_len,
  input  logic [PAT_MAX-1:0] i_cfg_gap,
  input  logic               i_valid,
  input  logic               i_sop,
  input  logic               i_eop,
  input  logic [BPC-1:0]     i_keep,
  input  logic [8*BPC-1:0]   i_data,
  output logic               o_hit,
  output logic               o_done,
  output logic               o_match
);

  localparam int unsigned LEN_W = 6;
  localparam int unsigned TBL_N = 256;

  logic [PAT_MAX-1:0] tbl_q [TBL_N];
  logic [PAT_MAX-1:0] tbl_d [TBL_N];
  logic [LEN_W-1:0]   len_q, len_d, cfg_len_norm;

  logic               s1_valid_q, s1_valid_d;
  logic               s1_sop_q, s1_sop_d;
  logic               s1_eop_q, s1_eop_d;
  logic [BPC-1:0]     s1_keep_q, s1_keep_d;
  logic [LEN_W-1:0]   s1_len_q, s1_len_d;
  logic [PAT_MAX-1:0] s1_m_q [BPC];
  logic [PAT_MAX-1:0] s1_m_d [BPC];

  logic [PAT_MAX-1:0] state_q, state_d;
  logic               sticky_q, sticky_d;
  logic               hit_q, hit_d;
  logic               done_q, done_d;
  logic               match_q, match_d;

  logic [PAT_MAX-1:0] d_w;
  logic [PAT_MAX-1:0] len_onehot;
  logic               beat_hit;

`ifdef SNI_BITAP_GAP_EN
  logic [PAT_MAX-1:0] gap_q, gap_d, s1_gap_q, s1_gap_d;
`else
  logic unused_gap;
  assign unused_gap = ^i_cfg_gap;
`endif

  // Out-of-range lengths fall back to the full state width
  always_comb begin
    cfg_len_norm = LEN_W'(i_cfg_len);
    if ((i_cfg_len == 5'd0) || (LEN_W'(i_cfg_len) > LEN_W'(PAT_MAX)))
      cfg_len_norm = LEN_W'(PAT_MAX);
  end

  // Mask table: write lands next cycle, same-cycle lookups see the old entry
  always_comb begin
    tbl_d = tbl_q;
    if (i_cfg_we) tbl_d[i_cfg_addr] = i_cfg_mask;
  end

  // Stage 1: capture per-byte lookups and beat attributes
  always_comb begin
    len_d      = len_q;
    s1_valid_d = i_valid;
    s1_sop_d   = s1_sop_q;
    s1_eop_d   = s1_eop_q;
    s1_keep_d  = s1_keep_q;
    s1_len_d   = s1_len_q;
    s1_m_d     = s1_m_q;
`ifdef SNI_BITAP_GAP_EN
    gap_d      = gap_q;
    s1_gap_d   = s1_gap_q;
`endif
    if (i_valid) begin
      s1_sop_d  = i_sop;
      s1_eop_d  = i_eop;
      s1_keep_d = i_keep;
      s1_len_d  = i_sop ? cfg_len_norm : len_q;
      if (i_sop) len_d = cfg_len_norm;
`ifdef SNI_BITAP_GAP_EN
      s1_gap_d = i_sop ? i_cfg_gap : gap_q;
      if (i_sop) gap_d = i_cfg_gap;
`endif
      for (int b = 0; b < int'(BPC); b++)
        s1_m_d[b] = tbl_q[i_data[8*b +: 8]];
    end
  end

  // Stage 2: walk the beat MSB-first, shifting the bitap state per kept byte
  always_comb begin
    state_d    = state_q;
    sticky_d   = sticky_q;
    hit_d      = 1'b0;
    done_d     = 1'b0;
    match_d    = 1'b0;
    beat_hit   = 1'b0;
    d_w        = s1_sop_q ? '1 : state_q;
    len_onehot = PAT_MAX'(1) << (s1_len_q - LEN_W'(1));
    for (int i = int'(BPC) - 1; i >= 0; i--) begin
      if (s1_keep_q[i]) begin
`ifdef SNI_BITAP_GAP_EN
        d_w = ((d_w << 1) | s1_m_q[i]) & (d_w | ~s1_gap_q);
`else
        d_w = (d_w << 1) | s1_m_q[i];
`endif
        if ((d_w & len_onehot) == '0) beat_hit = 1'b1;
      end
    end
    if (s1_valid_q) begin
      state_d  = d_w;
      hit_d    = beat_hit;
      sticky_d = (s1_sop_q ? 1'b0 : sticky_q) | beat_hit;
      done_d   = s1_eop_q;
      match_d  = s1_eop_q & sticky_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int a = 0; a < int'(TBL_N); a++) tbl_q[a] <= '1;
      for (int b = 0; b < int'(BPC); b++) s1_m_q[b] <= '1;
      len_q      <= LEN_W'(1);
      s1_valid_q <= 1'b0;
      s1_sop_q   <= 1'b0;
      s1_eop_q   <= 1'b0;
      s1_keep_q  <= '0;
      s1_len_q   <= LEN_W'(1);
      state_q    <= '1;
      sticky_q   <= 1'b0;
      hit_q      <= 1'b0;
      done_q     <= 1'b0;
      match_q    <= 1'b0;
`ifdef SNI_BITAP_GAP_EN
      gap_q      <= '0;
      s1_gap_q   <= '0;
`endif
    end else begin
      tbl_q      <= tbl_d;
      s1_m_q     <= s1_m_d;
      len_q      <= len_d;
      s1_valid_q <= s1_valid_d;
      s1_sop_q   <= s1_sop_d;
      s1_eop_q   <= s1_eop_d;
      s1_keep_q  <= s1_keep_d;
      s1_len_q   <= s1_len_d;
      state_q    <= state_d;
      sticky_q   <= sticky_d;
      hit_q      <= hit_d;
      done_q     <= done_d;
      match_q    <= match_d;
`ifdef SNI_BITAP_GAP_EN
      gap_q      <= gap_d;
      s1_gap_q   <= s1_gap_d;
`endif
    end
  end

  assign o_hit   = hit_q;
  assign o_done  = done_q;
  assign o_match = match_q;

endmodule
